// File: rtl/rf_cfg_pkg.sv
// Shared select-mode codes, scheduler state encoding and sizing/arbitration helpers.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package rf_cfg_pkg;

  // Bus owner codes presented on rf_cfg_select_mode
  typedef enum logic [2:0] {
    SEL_ADF  = 3'd0,
    SEL_ADS  = 3'd1,
    SEL_PARK = 3'd2
  } sel_mode_e;

  // Scheduler states; one transaction walks IDLE -> SETTLE -> START -> WAIT -> DONE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_e;

  // Width of a counter that runs 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin pick: a sole requester wins, a tie goes to whoever was not served last
  function automatic logic pick_ads(input logic adf_pend, input logic ads_pend,
                                    input logic last_ads);
    return ads_pend && (!adf_pend || !last_ads);
  endfunction

endpackage

// File: rtl/rf_mon_timer.sv
// Free-running monitor interval timer; ticks once per MON_PERIOD cycles while enabled.
// Latency: first tick is the MON_PERIOD-th enabled cycle; tick is decoded from the count register.
// Backpressure: none; ticks are fire-and-forget, the consumer coalesces them.
module rf_mon_timer
  import rf_cfg_pkg::*;
#(
  parameter int MON_PERIOD = 50000,
  localparam int MW = cnt_width(MON_PERIOD)
) (
  input  logic          spi_clk,
  input  logic          sys_rest_n,
  input  logic          mon_en,
  output logic          mon_tick,
  output logic [MW-1:0] mon_cnt
);

  localparam logic [MW-1:0] LAST = MW'(MON_PERIOD - 1);

  logic [MW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap   = mon_en && (r_cnt == LAST);
  assign mon_tick = w_wrap;
  assign mon_cnt  = r_cnt;

  // Count 0..MON_PERIOD-1 while enabled; disabling parks the count at zero
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_cnt <= '0;
    end else if (!mon_en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_spi_sched.sv
// Arbitrates the shared RF config SPI bus between ADF4351 setup and ADS8332 reads/monitoring.
// Latency: select changes the cycle after grant, start SETTLE cycles later, ack the cycle after spi_done.
// Backpressure: requests are levels held until ack; a busy bus simply delays the grant.
module rf_spi_sched
  import rf_cfg_pkg::*;
#(
  parameter int MON_PERIOD = 50000,
  parameter int SETTLE     = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic       spi_clk,
  input  logic       sys_rest_n,
  input  logic       adf_req,
  input  logic       ads_req,
  input  logic       mon_en,
  input  logic       spi_done,
  input  logic       err_clr,
  output logic [2:0] rf_cfg_select_mode,
  output logic       adf4351_spi_start,
  output logic       ads8332_spi_start,
  output logic       adf_ack,
  output logic       ads_ack,
  output logic       sched_busy,
  output logic       timeout_err,
  output logic       mon_ovf
);

  localparam int SW = cnt_width(SETTLE);
  localparam int TW = cnt_width(TIMEOUT);
  localparam int MW = cnt_width(MON_PERIOD);

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  sched_state_e  r_state;
  sched_state_e  w_state_nxt;
  logic          r_grant_ads;     // owner of the current transaction, and of the last one once idle
  logic [SW-1:0] r_settle_cnt;
  logic [TW-1:0] r_wait_cnt;
  logic          r_mon_pend;
  logic          r_timeout_err;
  logic          r_mon_ovf;

  logic          w_mon_tick;
  logic [MW-1:0] w_mon_cnt;
  logic          w_unused_mon_cnt;
  logic          w_ads_pend;
  logic          w_any_pend;
  logic          w_pick_ads;
  logic          w_grant_load;
  logic          w_settle_end;
  logic          w_timeout_hit;
  logic          w_wait_end;
  logic          w_pend_clr;
  sel_mode_e     w_grant_sel;

  rf_mon_timer #(
    .MON_PERIOD (MON_PERIOD)
  ) u_mon_timer (
    .spi_clk    (spi_clk),
    .sys_rest_n (sys_rest_n),
    .mon_en     (mon_en),
    .mon_tick   (w_mon_tick),
    .mon_cnt    (w_mon_cnt)
  );

  // The raw monitor count is a debug tap only; the scheduler acts on the tick
  assign w_unused_mon_cnt = ^w_mon_cnt;

  // A monitor tick stands in for a software ADS read until it is served
  assign w_ads_pend   = ads_req || r_mon_pend;
  assign w_any_pend   = adf_req || w_ads_pend;
  assign w_pick_ads   = pick_ads(adf_req, w_ads_pend, r_grant_ads);
  assign w_grant_load = (r_state == ST_IDLE) && w_any_pend;
  assign w_grant_sel  = r_grant_ads ? SEL_ADS : SEL_ADF;

  assign w_settle_end = (r_state == ST_SETTLE) && (r_settle_cnt == SETTLE_LAST);
  // spi_done on the last allowed cycle counts as a clean finish, not a timeout
  assign w_timeout_hit = (r_state == ST_WAIT) && !spi_done && (r_wait_cnt == TIMEOUT_LAST);
  assign w_wait_end    = (r_state == ST_WAIT) && (spi_done || (r_wait_cnt == TIMEOUT_LAST));
  assign w_pend_clr    = (r_state == ST_DONE) && r_grant_ads;

  assign timeout_err = r_timeout_err;
  assign mon_ovf     = r_mon_ovf;

  // State register; reset drops straight to IDLE and every decoded output follows at once
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore output decode from the registered state and grant
  always_comb begin
    w_state_nxt        = r_state;
    rf_cfg_select_mode = SEL_PARK;
    adf4351_spi_start  = 1'b0;
    ads8332_spi_start  = 1'b0;
    adf_ack            = 1'b0;
    ads_ack            = 1'b0;
    sched_busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_pend) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_settle_end) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        adf4351_spi_start = !r_grant_ads;
        ads8332_spi_start = r_grant_ads;
        w_state_nxt       = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_wait_end) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        adf_ack     = !r_grant_ads;
        ads_ack     = r_grant_ads;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (r_state != ST_IDLE) begin
      sched_busy         = 1'b1;
      rf_cfg_select_mode = w_grant_sel;
    end
  end

  // Latch the winner when leaving IDLE; it doubles as "last served" for round-robin
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_grant_ads <= 1'b1;
    end else if (w_grant_load) begin
      r_grant_ads <= w_pick_ads;
    end
  end

  // Settle guard counter: runs 0..SETTLE-1 inside SETTLE only
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_settle_cnt <= '0;
    end else if ((r_state == ST_SETTLE) && !w_settle_end) begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Transfer watchdog: runs 0..TIMEOUT-1 inside WAIT, cleared the moment WAIT ends
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !w_wait_end) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Pending monitor read: a fresh tick beats the clear from a finishing ADS transfer
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_mon_pend <= 1'b0;
    end else if (w_mon_tick) begin
      r_mon_pend <= 1'b1;
    end else if (w_pend_clr) begin
      r_mon_pend <= 1'b0;
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge spi_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      r_timeout_err <= 1'b0;
      r_mon_ovf     <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_hit || (r_timeout_err && !err_clr);
      r_mon_ovf     <= (w_mon_tick && r_mon_pend) || (r_mon_ovf && !err_clr);
    end
  end

endmodule

// File: tb/tb_rf_spi_sched.sv
// Bench for rf_spi_sched: directed latency/arbitration/timeout/reset scenarios plus random traffic.
// Latency: a transaction-level model predicts every output each cycle from the scheduling rules.
// Backpressure: requester holds a request until its ack (optionally), SPI engine answers after a set delay.
module tb_rf_spi_sched;

  localparam int P_MON = 100;
  localparam int P_SET = 16;
  localparam int P_TO  = 64;

  logic       spi_clk    = 1'b0;
  logic       sys_rest_n = 1'b0;
  logic       adf_req    = 1'b0;
  logic       ads_req    = 1'b0;
  logic       mon_en     = 1'b0;
  logic       spi_done   = 1'b0;
  logic       err_clr    = 1'b0;
  logic [2:0] sel;
  logic       adf_start, ads_start, adf_ack, ads_ack, busy, terr, movf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int done_delay = 10;   // cycles from start to spi_done; 0 means the engine never answers
  bit noise_en   = 1'b0; // stray spi_done pulses while no answer is scheduled
  bit auto_drop  = 1'b1; // requester releases its request when acked
  int cd         = 0;
  int adf_ack_cnt = 0;
  int ads_ack_cnt = 0;

  rf_spi_sched #(
    .MON_PERIOD (P_MON),
    .SETTLE     (P_SET),
    .TIMEOUT    (P_TO)
  ) dut (
    .spi_clk            (spi_clk),
    .sys_rest_n         (sys_rest_n),
    .adf_req            (adf_req),
    .ads_req            (ads_req),
    .mon_en             (mon_en),
    .spi_done           (spi_done),
    .err_clr            (err_clr),
    .rf_cfg_select_mode (sel),
    .adf4351_spi_start  (adf_start),
    .ads8332_spi_start  (ads_start),
    .adf_ack            (adf_ack),
    .ads_ack            (ads_ack),
    .sched_busy         (busy),
    .timeout_err        (terr),
    .mon_ovf            (movf)
  );

  always #5 spi_clk = ~spi_clk;

  always @(posedge spi_clk) cyc <= cyc + 1;

  // Ack counters sampled on the rising edge, i.e. the value held during the previous cycle
  always @(posedge spi_clk) begin
    if (adf_ack) adf_ack_cnt++;
    if (ads_ack) ads_ack_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SPI engine responder ----------------
  always @(negedge spi_clk) begin
    if (!sys_rest_n) begin
      cd       = 0;
      spi_done = 1'b0;
    end else begin
      spi_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) spi_done = 1'b1;
      end else if (noise_en && ($urandom_range(0, 15) == 0)) begin
        spi_done = 1'b1;
      end
      if ((adf_start || ads_start) && (done_delay > 0)) cd = done_delay;
    end
  end

  // ---------------- transaction-level reference model ----------------
  // m_age counts cycles since the grant: ages 0..SETTLE-1 settle, age SETTLE is the
  // start pulse, later ages are waiting; m_in_done marks the single ack cycle.
  bit m_busy      = 1'b0;
  bit m_grant_ads = 1'b1;
  bit m_last_ads  = 1'b1;
  bit m_in_done   = 1'b0;
  bit m_pend      = 1'b0;
  bit m_terr      = 1'b0;
  bit m_ovf       = 1'b0;
  int m_age       = 0;
  int m_mon_run   = 0;   // consecutive enabled cycles so far

  always @(posedge spi_clk or negedge sys_rest_n) begin
    bit tick, ovf_set, to_set, clr, adf_p, ads_p;
    int k;
    if (!sys_rest_n) begin
      m_busy = 0; m_grant_ads = 1; m_last_ads = 1; m_in_done = 0;
      m_pend = 0; m_terr = 0; m_ovf = 0; m_age = 0; m_mon_run = 0;
    end else begin
      tick      = mon_en && (((m_mon_run + 1) % P_MON) == 0);
      m_mon_run = mon_en ? m_mon_run + 1 : 0;
      ovf_set   = tick && m_pend;
      to_set    = 0;
      clr       = 0;
      if (!m_busy) begin
        adf_p = adf_req;
        ads_p = ads_req || m_pend;
        if (adf_p || ads_p) begin
          m_grant_ads = (adf_p && ads_p) ? !m_last_ads : ads_p;
          m_last_ads  = m_grant_ads;
          m_busy      = 1;
          m_age       = 0;
          m_in_done   = 0;
        end
      end else if (m_in_done) begin
        m_busy = 0;
        clr    = m_grant_ads;
      end else begin
        k = m_age - P_SET;  // wait-cycle number of the cycle just ending (1-based)
        if (k >= 1 && spi_done) begin
          m_in_done = 1;
        end else if (k >= 1 && k == P_TO) begin
          m_in_done = 1;
          to_set    = 1;
        end
        m_age++;
      end
      if (tick) m_pend = 1;
      else if (clr) m_pend = 0;
      if (to_set) m_terr = 1;
      else if (err_clr) m_terr = 0;
      if (ovf_set) m_ovf = 1;
      else if (err_clr) m_ovf = 0;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle
  always @(negedge spi_clk) begin
    logic [2:0] e_sel;
    if (sys_rest_n) begin
      e_sel = m_busy ? (m_grant_ads ? 3'd1 : 3'd0) : 3'd2;
      chk("select",      sel,       e_sel);
      chk("adf_start",   adf_start, m_busy && !m_in_done && (m_age == P_SET) && !m_grant_ads);
      chk("ads_start",   ads_start, m_busy && !m_in_done && (m_age == P_SET) && m_grant_ads);
      chk("adf_ack",     adf_ack,   m_busy && m_in_done && !m_grant_ads);
      chk("ads_ack",     ads_ack,   m_busy && m_in_done && m_grant_ads);
      chk("sched_busy",  busy,      m_busy);
      chk("timeout_err", terr,      m_terr);
      chk("mon_ovf",     movf,      m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge spi_clk);
    if (auto_drop && adf_ack) adf_req = 1'b0;
    if (auto_drop && ads_ack) ads_req = 1'b0;
  endtask

  function automatic logic probe(input int w);
    case (w)
      0: return adf_start;
      1: return ads_start;
      2: return adf_ack;
      3: return ads_ack;
      4: return busy;
      5: return (sel == 3'd0);
      6: return adf_start || ads_start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic val, input int limit,
                          input string name, output int at);
    int n = 0;
    while ((probe(w) !== val) && (n < limit)) begin
      step();
      n++;
    end
    at = cyc;
    if (probe(w) !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles, required %0d", name, limit, val);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t_req, t_sel, t_st, t_ak, s1, s2, s3, a0, d0;

    repeat (3) @(negedge spi_clk);
    chk("rst_select", sel, 3'd2);
    chk("rst_busy", busy, 0);
    chk("rst_adf_start", adf_start, 0);
    chk("rst_ads_start", ads_start, 0);
    chk("rst_acks", {30'd0, adf_ack, ads_ack}, 0);
    chk("rst_flags", {30'd0, terr, movf}, 0);

    // Tie straight out of reset: ADF first, then ADS, one ack each
    a0 = adf_ack_cnt; d0 = ads_ack_cnt;
    done_delay = 10;
    sys_rest_n = 1'b1;
    adf_req    = 1'b1;
    ads_req    = 1'b1;
    wait_for(6, 1'b1, 60, "tie_first_start", t_st);
    chk("tie_first_is_adf", adf_start, 1);
    chk("tie_model_grant_adf", m_grant_ads, 0);
    wait_for(2, 1'b1, 100, "tie_adf_ack", t_ak);
    step();
    wait_for(1, 1'b1, 100, "tie_ads_start", t_st);
    wait_for(3, 1'b1, 100, "tie_ads_ack", t_ak);
    step();
    chk("tie_adf_acks", adf_ack_cnt - a0, 1);
    chk("tie_ads_acks", ads_ack_cnt - d0, 1);

    // Single ADF request: select next cycle, start SETTLE later, ack after spi_done
    wait_for(4, 1'b0, 100, "b_idle", t_st);
    done_delay = 40;
    t_req   = cyc;
    adf_req = 1'b1;
    step();
    wait_for(5, 1'b1, 10, "b_select", t_sel);
    chk("b_req_to_select", t_sel - t_req, 1);
    wait_for(0, 1'b1, 40, "b_start", t_st);
    chk("b_select_to_start", t_st - t_sel, 16);
    wait_for(2, 1'b1, 80, "b_ack", t_ak);
    chk("b_start_to_ack", t_ak - t_st, 41);
    step();
    chk("b_select_parked", sel, 3'd2);

    // Engine never answers: 64 wait cycles, error flag, ack still issued
    wait_for(4, 1'b0, 100, "c_idle", t_st);
    done_delay = 0;
    adf_req    = 1'b1;
    wait_for(0, 1'b1, 40, "c_start", t_st);
    wait_for(2, 1'b1, 120, "c_ack", t_ak);
    chk("c_start_to_ack", t_ak - t_st, 65);
    chk("c_timeout_err_set", terr, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("c_timeout_err_clr", terr, 0);

    // spi_done on exactly the timeout cycle is a clean finish
    wait_for(4, 1'b0, 100, "d_idle", t_st);
    done_delay = 64;
    ads_req    = 1'b1;
    wait_for(1, 1'b1, 40, "d_start", t_st);
    wait_for(3, 1'b1, 120, "d_ack", t_ak);
    chk("d_start_to_ack", t_ak - t_st, 65);
    chk("d_no_timeout_err", terr, 0);

    // Periodic monitor with no other traffic: one ADS start every MON_PERIOD cycles
    step();
    wait_for(4, 1'b0, 100, "e_idle", t_st);
    done_delay = 20;
    mon_en     = 1'b1;
    wait_for(1, 1'b1, 150, "e_start1", s1);
    step();
    wait_for(1, 1'b1, 150, "e_start2", s2);
    step();
    wait_for(1, 1'b1, 150, "e_start3", s3);
    chk("e_period_1", s2 - s1, 100);
    chk("e_period_2", s3 - s2, 100);
    chk("e_no_ovf", movf, 0);

    // Slow engine plus constant ADF traffic keeps a tick pending -> overflow
    done_delay = 100;
    auto_drop  = 1'b0;
    adf_req    = 1'b1;
    repeat (400) step();
    chk("e_ovf_set", movf, 1);
    adf_req   = 1'b0;
    auto_drop = 1'b1;
    mon_en    = 1'b0;
    repeat (200) step();
    wait_for(4, 1'b0, 100, "e_idle2", t_st);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("e_ovf_clr", movf, 0);
    chk("e_terr_clr", terr, 0);

    // Reset pulse in WAIT: immediate park, no ack, held request served again
    done_delay = 0;
    adf_req    = 1'b1;
    wait_for(0, 1'b1, 40, "f_start", t_st);
    repeat (5) step();
    a0 = adf_ack_cnt;
    #2 sys_rest_n = 1'b0;
    #1;
    chk("f_rst_select", sel, 3'd2);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_start", {30'd0, adf_start, ads_start}, 0);
    chk("f_rst_ack", {30'd0, adf_ack, ads_ack}, 0);
    step();
    sys_rest_n = 1'b1;
    done_delay = 10;
    wait_for(0, 1'b1, 40, "f_reserve_start", t_st);
    chk("f_reserve_start", adf_start, 1);
    chk("f_no_ack_on_abort", adf_ack_cnt - a0, 0);
    wait_for(2, 1'b1, 40, "f_reserve_ack", t_ak);
    step();
    chk("f_one_ack", adf_ack_cnt - a0, 1);

    // Random traffic checked cycle-by-cycle against the model
    noise_en = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 24) == 0) adf_req = 1'b1;
      if ($urandom_range(0, 24) == 0) ads_req = 1'b1;
      if ($urandom_range(0, 99) == 0) adf_req = 1'b0;
      if ($urandom_range(0, 99) == 0) ads_req = 1'b0;
      if ($urandom_range(0, 199) == 0) mon_en = ~mon_en;
      err_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) done_delay = $urandom_range(0, 72);
      if ($urandom_range(0, 999) == 0) begin
        sys_rest_n = 1'b0;
        step();
        sys_rest_n = 1'b1;
      end
    end
    err_clr = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
